// File: rtl/ysyx_24090013_defs.sv
// Shared definitions for the instruction fetch unit: state encoding,
// fault codes, bus response code and the bubble instruction.
package ysyx_24090013_defs;

  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_AR    = 3'd1,
    IFU_R     = 3'd2,
    IFU_OUT   = 3'd3,
    IFU_DRAIN = 3'd4
  } ifu_state_e;

  localparam logic [1:0]  FAULT_OK       = 2'b00;
  localparam logic [1:0]  FAULT_BUS      = 2'b01;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b10;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24090013_RegAN.sv
// Generic enable register with asynchronous active-low reset.
module ysyx_24090013_RegAN #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= RESET_VAL;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ysyx_24090013_ifu.sv
// Instruction fetch unit: one PC in, one single-beat AR/R read, one
// {pc, inst, fault} bundle out to ID; EX flush discards in-flight work.
//
// state     | meaning
// IFU_IDLE  | waiting for a PC from the PC stage
// IFU_AR    | read address presented, waiting for arready
// IFU_R     | waiting for read data
// IFU_OUT   | bundle presented to ID
// IFU_DRAIN | fetch killed, swallowing the outstanding read response
module ysyx_24090013_ifu #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(ysyx_24090013_defs::NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        id_fault,
  input  logic              id_ready,
  output logic [31:0]       fetch_cnt
);

  import ysyx_24090013_defs::*;

  ifu_state_e        r_state;
  ifu_state_e        w_next;
  logic              r_kill;
  logic [31:0]       r_fetch_cnt;

  logic              w_pc_ready;
  logic              w_pc_fire;
  logic              w_misalign;
  logic              w_r_take;
  logic              w_inst_en;
  logic [INST_W-1:0] w_inst_d;
  logic [1:0]        w_fault_d;
  logic [ADDR_W-1:0] w_pc_q;
  logic [INST_W-1:0] w_inst_q;
  logic [1:0]        w_fault_q;

  assign w_misalign = (pc_addr[1:0] != 2'b00);

  always_comb begin
    w_next     = r_state;
    w_pc_ready = 1'b0;
    case (r_state)
      IFU_IDLE: w_pc_ready = !flush;
      IFU_OUT:  w_pc_ready = !flush && id_ready;
      default:  w_pc_ready = 1'b0;
    endcase
    // pc_ready is combinational from flush, so gate it explicitly while in reset
    w_pc_ready = w_pc_ready && rst;
    w_pc_fire  = pc_valid && w_pc_ready;

    case (r_state)
      IFU_IDLE: begin
        if (w_pc_fire) w_next = w_misalign ? IFU_OUT : IFU_AR;
      end
      IFU_AR: begin
        if (mem_arready) w_next = (r_kill || flush) ? IFU_DRAIN : IFU_R;
      end
      IFU_R: begin
        if (mem_rvalid) w_next = flush ? IFU_IDLE : IFU_OUT;
        else if (flush) w_next = IFU_DRAIN;
      end
      IFU_DRAIN: begin
        if (mem_rvalid) w_next = IFU_IDLE;
      end
      IFU_OUT: begin
        if (flush)         w_next = IFU_IDLE;
        else if (id_ready) w_next = w_pc_fire ? (w_misalign ? IFU_OUT : IFU_AR) : IFU_IDLE;
      end
      default: w_next = IFU_IDLE;
    endcase
  end

  assign w_r_take  = (r_state == IFU_R) && mem_rvalid && !flush;
  assign w_inst_en = w_pc_fire || w_r_take;

  always_comb begin
    w_inst_d  = NOP_INST;
    w_fault_d = FAULT_OK;
    if (w_pc_fire) begin
      w_fault_d = w_misalign ? FAULT_MISALIGN : FAULT_OK;
    end else if (mem_rresp == RESP_OKAY) begin
      w_inst_d  = mem_rdata;
    end else begin
      w_fault_d = FAULT_BUS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IFU_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_kill <= 1'b0;
    else if (w_next == IFU_IDLE)            r_kill <= 1'b0;
    else if ((r_state == IFU_AR) && flush)  r_kill <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_fetch_cnt <= 32'd0;
    else if (id_valid && id_ready) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  ysyx_24090013_RegAN #(.WIDTH(ADDR_W), .RESET_VAL(ADDR_W'(0))) u_pc_q (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_pc_fire),
    .i_d   (pc_addr),
    .o_q   (w_pc_q)
  );

  ysyx_24090013_RegAN #(.WIDTH(INST_W), .RESET_VAL(NOP_INST)) u_inst_q (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_inst_en),
    .i_d   (w_inst_d),
    .o_q   (w_inst_q)
  );

  ysyx_24090013_RegAN #(.WIDTH(2), .RESET_VAL(FAULT_OK)) u_fault_q (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_inst_en),
    .i_d   (w_fault_d),
    .o_q   (w_fault_q)
  );

  assign pc_ready    = w_pc_ready;
  assign mem_arvalid = (r_state == IFU_AR);
  assign mem_araddr  = w_pc_q;
  assign mem_rready  = (r_state == IFU_R) || (r_state == IFU_DRAIN);
  assign id_valid    = (r_state == IFU_OUT) && !flush;
  assign id_pc       = w_pc_q;
  assign id_inst     = w_inst_q;
  assign id_fault    = w_fault_q;
  assign fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_24090013_ifu.sv
// Bench for the fetch unit: directed scenarios plus randomized traffic,
// checked against a transaction-level model of expected bundles.
module tb_ysyx_24090013_ifu;

  localparam logic [31:0] EXP_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        pc_ready;
  logic        flush;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  id_fault;
  logic        id_ready;
  logic [31:0] fetch_cnt;

  ysyx_24090013_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .pc_valid    (pc_valid),
    .pc_addr     (pc_addr),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .mem_arvalid (mem_arvalid),
    .mem_araddr  (mem_araddr),
    .mem_arready (mem_arready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rready  (mem_rready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_fault    (id_fault),
    .id_ready    (id_ready),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] pc_fifo[$];

  // model of the single fetch in flight and of the memory slave
  bit          exp_valid;
  logic [31:0] exp_pc, last_pc, bus_addr;
  bit          bus_busy;
  int          r_cnt, r_lat, ar_hold, ar_wait;
  bit          rnd_mode;
  logic [31:0] cnt;
  int          t_acc, lat_ar, lat_id, ar_cnt;
  bit          ar_seen, idv_seen, hs, b2b, seen_bad;
  bit          prev_ar_stall, prev_id_stall;
  logic [31:0] prev_pc, prev_inst;
  logic [1:0]  prev_fault;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0297;
    if (a == 32'h8000_0040) return 32'h1111_1111;
    if (a[11:8] == 4'hB)    return 32'hDEAD_BEEF;
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return (a[11:8] == 4'hB) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if (a[1:0] != 2'b00)          return EXP_NOP;
    if (mem_resp(a) != 2'b00)     return EXP_NOP;
    return mem_data(a);
  endfunction

  function automatic logic [1:0] exp_fault(input logic [31:0] a);
    if (a[1:0] != 2'b00)          return 2'b10;
    if (mem_resp(a) != 2'b00)     return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    a = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
    if ($urandom_range(0, 7) == 0) a[1:0]  = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 7) == 0) a[11:8] = 4'hB;
    return a;
  endfunction

  task automatic offer(input logic [31:0] a);
    pc_fifo.push_back(a);
    pc_valid = 1'b1;
    pc_addr  = pc_fifo[0];
  endtask

  // one clock: check and update the model at negedge, drive inputs after posedge
  task automatic step();
    bit pc_f, ar_f, r_f, id_f;
    @(negedge clk);
    cyc++;
    pc_f = pc_valid && pc_ready;
    ar_f = mem_arvalid && mem_arready;
    r_f  = mem_rvalid && mem_rready;
    id_f = id_valid && id_ready;

    chk("ar_r_exclusive", 96'(mem_arvalid && mem_rready), 96'(0));
    if (mem_arvalid || bus_busy) chk("pc_ready_while_busy", 96'(pc_ready), 96'(0));
    if (mem_arvalid) begin
      chk("araddr", 96'(mem_araddr), 96'(last_pc));
      ar_cnt++;
      if (!ar_seen) begin ar_seen = 1; lat_ar = cyc - t_acc; end
    end
    if (prev_ar_stall) chk("arvalid_held", 96'(mem_arvalid), 96'(1));
    if (id_valid) begin
      chk("id_valid_expected", 96'(exp_valid), 96'(1));
      if (!idv_seen) begin idv_seen = 1; lat_id = cyc - t_acc; end
      if (id_inst == 32'h1111_1111) seen_bad = 1;
    end
    if (prev_id_stall && !flush) begin
      chk("id_hold_valid", 96'(id_valid), 96'(1));
      chk("id_hold_bundle", {id_pc, id_inst, id_fault}, {prev_pc, prev_inst, prev_fault});
    end
    chk("fetch_cnt", 96'(fetch_cnt), 96'(cnt));

    if (id_f) begin
      chk("id_pc",    96'(id_pc),    96'(exp_pc));
      chk("id_inst",  96'(id_inst),  96'(exp_inst(exp_pc)));
      chk("id_fault", 96'(id_fault), 96'(exp_fault(exp_pc)));
      cnt++;
      exp_valid = 0;
      hs = 1;
    end
    if (flush) exp_valid = 0;
    if (pc_f) begin
      exp_valid = 1; exp_pc = pc_addr; last_pc = pc_addr;
      t_acc = cyc; ar_seen = 0; idv_seen = 0; ar_cnt = 0; b2b = id_f;
    end
    if (ar_f) begin
      bus_busy = 1; bus_addr = mem_araddr; r_cnt = r_lat; ar_wait = 0;
      if (rnd_mode) begin ar_hold = $urandom_range(0, 2); r_lat = $urandom_range(0, 3); end
    end else if (mem_arvalid) begin
      ar_wait++;
    end
    if (r_f) bus_busy = 0;
    prev_ar_stall = mem_arvalid && !mem_arready;
    prev_id_stall = id_valid && !id_ready;
    prev_pc = id_pc; prev_inst = id_inst; prev_fault = id_fault;

    @(posedge clk);
    #1;
    if (pc_f) void'(pc_fifo.pop_front());
    if (rnd_mode) begin
      if (pc_fifo.size() == 0 && $urandom_range(0, 2) == 0) pc_fifo.push_back(rand_pc());
      flush    = ($urandom_range(0, 11) == 0);
      id_ready = ($urandom_range(0, 9) < 7);
    end
    pc_valid = (pc_fifo.size() > 0);
    pc_addr  = (pc_fifo.size() > 0) ? pc_fifo[0] : 32'h0;
    mem_arready = mem_arvalid && (ar_wait >= ar_hold);
    if (r_f) begin
      mem_rvalid = 1'b0;
    end else if (bus_busy && !mem_rvalid) begin
      if (r_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_data(bus_addr);
        mem_rresp  = mem_resp(bus_addr);
      end else begin
        r_cnt--;
      end
    end
  endtask

  task automatic wait_hs(input int max, input string tag);
    hs = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (hs) break;
    end
    chk(tag, 96'(hs), 96'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_ready"},  96'(pc_ready),    96'(0));
    chk({tag, "_arvalid"},   96'(mem_arvalid), 96'(0));
    chk({tag, "_rready"},    96'(mem_rready),  96'(0));
    chk({tag, "_id_valid"},  96'(id_valid),    96'(0));
    chk({tag, "_id_pc"},     96'(id_pc),       96'(0));
    chk({tag, "_id_inst"},   96'(id_inst),     96'(EXP_NOP));
    chk({tag, "_id_fault"},  96'(id_fault),    96'(0));
    chk({tag, "_fetch_cnt"}, 96'(fetch_cnt),   96'(0));
  endtask

  task automatic model_reset();
    pc_fifo.delete();
    exp_valid = 0; bus_busy = 0; cnt = 0; ar_wait = 0; r_cnt = 0;
    prev_ar_stall = 0; prev_id_stall = 0;
    pc_valid = 0; pc_addr = 0; flush = 0; mem_arready = 0; mem_rvalid = 0;
    mem_rdata = 0; mem_rresp = 0;
  endtask

  initial begin
    logic [31:0] cnt_before;
    rst = 1'b0; rnd_mode = 0; ar_hold = 0; r_lat = 0; id_ready = 0;
    t_acc = 0; seen_bad = 0; b2b = 0;
    model_reset();
    pc_valid = 1'b1; pc_addr = 32'h8000_0000;
    #12;
    check_reset_outputs("rst0");
    pc_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // T1: zero-wait fetch, latency and content
    id_ready = 1;
    offer(32'h8000_0000);
    wait_hs(10, "t1_handshake");
    chk("t1_lat_ar", 96'(lat_ar), 96'(1));
    chk("t1_lat_id", 96'(lat_id), 96'(3));
    chk("t1_cnt", 96'(fetch_cnt), 96'(1));

    // T2: misaligned PC, no bus traffic
    offer(32'h8000_0002);
    wait_hs(10, "t2_handshake");
    chk("t2_ar_cnt", 96'(ar_cnt), 96'(0));
    chk("t2_lat_id", 96'(lat_id), 96'(1));

    // T3: bus error response
    offer(32'h8000_0B00);
    wait_hs(10, "t3_handshake");

    // T4: flush in R, slow response dropped, next PC waits for drain
    cnt_before = cnt;
    r_lat = 3;
    offer(32'h8000_0040);
    offer(32'h8000_0044);
    step();
    step();
    flush = 1;
    step();
    flush = 0;
    wait_hs(30, "t4_handshake");
    chk("t4_no_dropped_data", 96'(seen_bad), 96'(0));
    chk("t4_cnt", 96'(fetch_cnt), 96'(cnt_before + 1));

    // T5: arready held off 4 cycles, flush in the second AR cycle
    ar_hold = 4; r_lat = 0;
    offer(32'h8000_0080);
    step();
    step();
    flush = 1;
    step();
    flush = 0;
    repeat (3) step();
    chk("t5_ar_cycles", 96'(ar_cnt), 96'(5));
    ar_hold = 0;
    offer(32'h8000_0100);
    wait_hs(20, "t5_handshake");
    chk("t5_lat_id", 96'(lat_id), 96'(3));
    chk("t5_ar_cnt", 96'(ar_cnt), 96'(1));

    // T6: ID stalls, then back-to-back acceptance in OUT
    cnt_before = cnt;
    id_ready = 0;
    offer(32'h8000_0000);
    offer(32'h8000_0004);
    idv_seen = 0;
    for (int i = 0; i < 10 && !idv_seen; i++) step();
    chk("t6_id_valid_seen", 96'(idv_seen), 96'(1));
    repeat (5) step();
    id_ready = 1;
    wait_hs(10, "t6_handshake1");
    wait_hs(10, "t6_handshake2");
    chk("t6_back_to_back", 96'(b2b), 96'(1));
    chk("t6_cnt", 96'(fetch_cnt), 96'(cnt_before + 2));

    // reset asserted while a read is outstanding
    r_lat = 5;
    offer(32'h8000_0200);
    step();
    step();
    #2 rst = 1'b0;
    pc_valid = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;

    // randomized traffic
    rnd_mode = 1; ar_hold = 0; r_lat = 0;
    repeat (2000) step();
    rnd_mode = 0; flush = 0; id_ready = 1;
    for (int i = 0; i < 200; i++) begin
      if (pc_fifo.size() == 0 && !exp_valid && !bus_busy) break;
      step();
    end
    chk("final_drain", 96'(pc_fifo.size() == 0 && !exp_valid && !bus_busy), 96'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_24090013_ifu.md
Name: ysyx_24090013_ifu

Overview:
Instruction fetch unit, directly downstream of the PC generator. Accepts one PC at a time over a valid/ready handshake and issues a single-beat read on a simplified AXI-lite style AR/R instruction port. Presents {pc, inst, fault} to the ID stage over valid/ready and discards in-flight fetches when EX redirects (flush).

Parameters:
ADDR_W, 32, PC / fetch address width
INST_W, 32, instruction / read data width
NOP_INST, 32'h0000_0013, instruction word driven on id_inst for faulted fetches

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
pc_valid  in  1  PC stage offers pc_addr
pc_addr  in  ADDR_W  fetch PC
pc_ready  out  1  IFU accepts pc_addr this cycle
flush  in  1  EX redirect; kills current fetch
mem_arvalid  out  1  read address valid
mem_araddr  out  ADDR_W  read address (= latched PC)
mem_arready  in  1  address accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  INST_W  read data
mem_rresp  in  2  00 = OK, else bus error
mem_rready  out  1  IFU accepts read data
id_valid  out  1  fetched bundle valid
id_pc  out  ADDR_W  PC of bundle
id_inst  out  INST_W  instruction
id_fault  out  2  00 ok, 01 bus error, 10 misaligned
id_ready  in  1  ID consumes bundle
fetch_cnt  out  32  count of bundles handed to ID, wraps at 2^32

Behaviour:
- Reset (rst=0, async): state=IDLE, pc_q=0, inst_q=NOP_INST, fault_q=0, fetch_cnt=0. All valid/ready outputs 0 while in reset.
- States: IDLE, AR, R, OUT, DRAIN.
- IDLE: pc_ready=!flush.
  - pc_valid & pc_ready: latch pc_addr.
    - pc_addr[1:0]!=0: fault_q=10, inst_q=NOP_INST, next state OUT, no bus access.
    - Otherwise: next state AR.
- AR: mem_arvalid=1, mem_araddr=pc_q. arvalid stays high and araddr stays stable until arready.
  - A flush during AR sets kill_q. On arready, go to DRAIN if kill_q|flush, else R.
- R: mem_rready=1.
  - rvalid & !flush: inst_q=rdata, fault_q = (rresp!=0) ? 01 : 00, next state OUT.
  - Bus error: inst_q=NOP_INST.
  - flush & rvalid in the same cycle: data dropped, next state IDLE.
  - flush without rvalid: next state DRAIN.
- DRAIN: mem_rready=1, pc_ready=0. On rvalid, data dropped, next state IDLE. Flush here has no further effect.
- OUT: id_valid=!flush. id_pc/id_inst/id_fault are driven from registers and are stable while id_valid & !id_ready.
  - flush: bundle dropped, next state IDLE, fetch_cnt unchanged.
  - id_ready & id_valid: fetch_cnt+=1.
    - If pc_valid also high, pc_ready=1 in OUT, the new PC is latched, and the next state is AR (or OUT on misalignment). This gives back-to-back fetch.
    - Otherwise next state IDLE.
- Latency with zero-wait memory: PC accepted cycle N, arvalid N+1, rvalid N+2, id_valid N+3. Sustained throughput is one bundle per 3 cycles.
- Only one outstanding read, ever. kill_q clears on entering IDLE.
- Invariants:
  - mem_arvalid and mem_rready are never both high.
  - id_valid is never high outside OUT.
  - pc_ready is never high in AR, R, or DRAIN.

Decomposition:
- Shared package/header ysyx_24090013_defs holds:
  - state encoding (IFU_IDLE=0 … IFU_DRAIN=4)
  - fault codes FAULT_OK/FAULT_BUS/FAULT_MISALIGN
  - NOP_INST
  - RESP_OKAY
- Pipeline registers (pc_q, inst_q, fault_q) reuse the existing generic enable register with async-low reset variant ysyx_24090013_RegAN (WIDTH, RESET_VAL).
- No other sub-module.

Test Plan:
1. Reset release, pc_valid=1 pc_addr=0x8000_0000, arready=1, rvalid next cycle rdata=0x0000_0297 rresp=0 → id_valid at N+3, id_pc=0x8000_0000, id_inst=0x0000_0297, id_fault=0, fetch_cnt=1 after id_ready.
2. pc_addr=0x8000_0002 → no arvalid ever, id_valid at N+1, id_inst=0x0000_0013, id_fault=10.
3. rresp=2'b10 with rdata=0xDEAD_BEEF → id_inst=0x0000_0013, id_fault=01.
4. Flush while in R with rvalid 3 cycles later (rdata=0x1111_1111) → DRAIN, rready held, data never appears on id_inst, pc_ready=0 until DRAIN exits, fetch_cnt unchanged.
5. arready held low 4 cycles with flush pulsed in cycle 2 → arvalid/araddr stable all 4 cycles, then DRAIN, response discarded, next PC 0x8000_0100 fetched normally.
6. id_ready=0 for 5 cycles then 1, with pc_valid high, PCs 0x8000_0000/0x8000_0004 → bundle held stable, back-to-back acceptance in OUT, fetch_cnt=2; assert rst low mid-R → all outputs return to reset values immediately.
